// File: rtl/rv32i_cpu.sv
// rv32i_cpu: multicycle RV32I core (FETCH/EXECUTE/MEMORY); define RVFI_TRACE_EN to add the commit_* retirement trace ports
module rv32i_cpu #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
`ifdef RVFI_TRACE_EN
    ,
    output logic        commit_valid,
    output logic [63:0] commit_order,
    output logic [31:0] commit_pc_rdata,
    output logic [31:0] commit_pc_wdata,
    output logic [31:0] commit_insn,
    output logic [4:0]  commit_rd_addr,
    output logic [31:0] commit_rd_wdata
`endif
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [1:0] {FETCH, EXECUTE, MEMORY} state_t;

    state_t      state, state_next;
    logic [31:0] pc, ir;
    logic [31:0] rf [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] rs1v, rs2v;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b, alu_out, pc_plus4, pc_next, wb_val;
    logic [4:0]  shamt;
    logic        wb_en, is_load, is_store, is_mem;
    logic        eq, lt_s, lt_u, taken;
    logic [31:0] ea, st_data, ld_sh, ld_val;
    logic [3:0]  smask, lane_mask;

    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign f3       = ir[14:12];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign f7b5     = ir[30];
    assign rs1v     = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2v     = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    assign imm_i    = {{20{ir[31]}}, ir[31:20]};
    assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u    = {ir[31:12], 12'd0};
    assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;

    assign eq    = rs1v == rs2v;
    assign lt_s  = $signed(rs1v) < $signed(rs2v);
    assign lt_u  = rs1v < rs2v;
    assign taken = (f3 == 3'd0) ? eq :
                   (f3 == 3'd1) ? !eq :
                   (f3 == 3'd4) ? lt_s :
                   (f3 == 3'd5) ? !lt_s :
                   (f3 == 3'd6) ? lt_u :
                   (f3 == 3'd7) ? !lt_u : 1'b0;

    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_mem    = is_load || is_store;
    assign ea        = rs1v + (is_store ? imm_s : imm_i);
    assign smask     = (f3[1:0] == 2'd0) ? 4'b0001 : (f3[1:0] == 2'd1) ? 4'b0011 : 4'b1111;
    assign lane_mask = smask << ea[1:0];
    assign st_data   = rs2v << {ea[1:0], 3'b000};
    assign ld_sh     = dmem_rdata >> {ea[1:0], 3'b000};
    assign ld_val    = (f3 == 3'd0) ? {{24{ld_sh[7]}}, ld_sh[7:0]} :
                       (f3 == 3'd1) ? {{16{ld_sh[15]}}, ld_sh[15:0]} :
                       (f3 == 3'd4) ? {24'd0, ld_sh[7:0]} :
                       (f3 == 3'd5) ? {16'd0, ld_sh[15:0]} : ld_sh;

    assign imem_addr  = {pc[31:2], 2'b00};
    assign imem_rmask = (state == FETCH && !rst) ? 4'hF : 4'h0;

    // ALU for OP and OP-IMM; only register-register ops use bit 30 to pick SUB
    always_comb begin
        op_b    = (opcode == OP_OP) ? rs2v : imm_i;
        shamt   = op_b[4:0];
        alu_out = 32'd0;
        case (f3)
            3'd0: alu_out = (opcode == OP_OP && f7b5) ? rs1v - op_b : rs1v + op_b;
            3'd1: alu_out = rs1v << shamt;
            3'd2: alu_out = {31'd0, $signed(rs1v) < $signed(op_b)};
            3'd3: alu_out = {31'd0, rs1v < op_b};
            3'd4: alu_out = rs1v ^ op_b;
            3'd5: alu_out = f7b5 ? 32'($signed(rs1v) >>> shamt) : rs1v >> shamt;
            3'd6: alu_out = rs1v | op_b;
            default: alu_out = rs1v & op_b;
        endcase
    end

    // writeback value and next pc for instructions retiring in EXECUTE; unknown opcodes fall through as no-ops
    always_comb begin
        pc_next = pc_plus4;
        wb_en   = 1'b0;
        wb_val  = alu_out;
        case (opcode)
            OP_LUI:    begin wb_en = 1'b1; wb_val = imm_u; end
            OP_AUIPC:  begin wb_en = 1'b1; wb_val = pc + imm_u; end
            OP_JAL:    begin wb_en = 1'b1; wb_val = pc_plus4; pc_next = pc + imm_j; end
            OP_JALR:   begin wb_en = 1'b1; wb_val = pc_plus4; pc_next = (rs1v + imm_i) & ~32'd1; end
            OP_BRANCH: pc_next = taken ? pc + imm_b : pc_plus4;
            OP_IMM, OP_OP: wb_en = 1'b1;
            default: ;
        endcase
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem_resp) state_next = EXECUTE;
            EXECUTE: state_next = is_mem ? MEMORY : FETCH;
            MEMORY:  if (dmem_resp) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? FETCH : state_next;
    end

    // datapath: instruction latch, register file, pc and registered data-bus request
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir         <= 32'd0;
            dmem_addr  <= 32'd0;
            dmem_rmask <= 4'h0;
            dmem_wmask <= 4'h0;
            dmem_wdata <= 32'd0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            if (state == FETCH && imem_resp) ir <= imem_rdata;
            if (state == EXECUTE) begin
                if (is_mem) begin
                    dmem_addr  <= {ea[31:2], 2'b00};
                    dmem_rmask <= is_load ? lane_mask : 4'h0;
                    dmem_wmask <= is_store ? lane_mask : 4'h0;
                    dmem_wdata <= is_store ? st_data : 32'd0;
                end else begin
                    pc <= pc_next;
                    if (wb_en && rd != 5'd0) rf[rd] <= wb_val;
                end
            end
            if (state == MEMORY && dmem_resp) begin
                pc         <= pc_plus4;
                dmem_rmask <= 4'h0;
                dmem_wmask <= 4'h0;
                if (is_load && rd != 5'd0) rf[rd] <= ld_val;
            end
        end
    end

`ifdef RVFI_TRACE_EN
    logic        retire, rd_wr;
    logic [63:0] order_cnt;

    assign retire = (state == EXECUTE && !is_mem) || (state == MEMORY && dmem_resp);
    assign rd_wr  = (state == MEMORY ? is_load : wb_en) && rd != 5'd0;

    // one-cycle commit record registered on each retirement
    always_ff @(posedge clk) begin
        if (rst) begin
            order_cnt       <= 64'd0;
            commit_valid    <= 1'b0;
            commit_order    <= 64'd0;
            commit_pc_rdata <= 32'd0;
            commit_pc_wdata <= 32'd0;
            commit_insn     <= 32'd0;
            commit_rd_addr  <= 5'd0;
            commit_rd_wdata <= 32'd0;
        end else begin
            commit_valid <= retire;
            if (retire) begin
                order_cnt       <= order_cnt + 64'd1;
                commit_order    <= order_cnt;
                commit_pc_rdata <= pc;
                commit_pc_wdata <= (state == MEMORY) ? pc_plus4 : pc_next;
                commit_insn     <= ir;
                commit_rd_addr  <= rd_wr ? rd : 5'd0;
                commit_rd_wdata <= rd_wr ? ((state == MEMORY) ? ld_val : wb_val) : 32'd0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rv32i_cpu.sv
// tb_rv32i_cpu: directed self-checking bench for rv32i_cpu; the bench plays both memories and observes registers through stores
module tb_rv32i_cpu;
    localparam logic [31:0] P = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic [3:0]  imem_rmask;
    logic        imem_resp = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic        dmem_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    rv32i_cpu dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic fetch(input logic [31:0] addr, input logic [31:0] insn);
        int n = 0;
        while (imem_rmask !== 4'hF && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_rmask", 32'(imem_rmask), 32'hF);
        chk("fetch_addr", imem_addr, addr);
        chk("fetch_dmask_idle", 32'(dmem_rmask | dmem_wmask), 32'd0);
        @(negedge clk);
        chk("fetch_hold_addr", imem_addr, addr);
        imem_resp  = 1'b1;
        imem_rdata = insn;
        @(negedge clk);
        imem_resp  = 1'b0;
        imem_rdata = 32'd0;
        chk("fetch_rmask_drop", 32'(imem_rmask), 32'd0);
    endtask

    task automatic mem(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] rdata);
        int n = 0;
        while ((dmem_rmask | dmem_wmask) === 4'h0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mem_addr", dmem_addr, addr);
        chk("mem_rmask", 32'(dmem_rmask), 32'(rm));
        chk("mem_wmask", 32'(dmem_wmask), 32'(wm));
        if (wm != 4'h0) chk("mem_wdata", dmem_wdata, wd);
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = 32'd0;
        chk("mem_masks_clear", 32'(dmem_rmask | dmem_wmask), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_imem_rmask", 32'(imem_rmask), 32'd0);
        chk("rst_dmem_masks", 32'(dmem_rmask | dmem_wmask), 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("first_fetch_addr", imem_addr, P);
        chk("first_fetch_rmask", 32'(imem_rmask), 32'hF);

        fetch(P + 32'h00, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'b0010011));
        fetch(P + 32'h04, enc_i(12'd28, 5'd1, 3'd5, 5'd2, 7'b0010011));
        fetch(P + 32'h08, enc_s(12'd0, 5'd1, 5'd0, 3'd2));
        mem(32'h0, 4'h0, 4'hF, 32'hFFFFFFFF, 32'd0);
        fetch(P + 32'h0C, enc_s(12'd4, 5'd2, 5'd0, 3'd2));
        mem(32'h4, 4'h0, 4'hF, 32'h0000000F, 32'd0);
        fetch(P + 32'h10, enc_i(12'h0AB, 5'd0, 3'd0, 5'd3, 7'b0010011));
        fetch(P + 32'h14, enc_s(12'd2, 5'd3, 5'd0, 3'd0));
        mem(32'h0, 4'h0, 4'b0100, 32'h00AB0000, 32'd0);
        fetch(P + 32'h18, enc_i(12'd3, 5'd0, 3'd0, 5'd4, 7'b0000011));
        mem(32'h0, 4'b1000, 4'h0, 32'd0, 32'h80000000);
        fetch(P + 32'h1C, enc_i(12'd3, 5'd0, 3'd4, 5'd5, 7'b0000011));
        mem(32'h0, 4'b1000, 4'h0, 32'd0, 32'h80000000);
        fetch(P + 32'h20, enc_s(12'd8, 5'd4, 5'd0, 3'd2));
        mem(32'h8, 4'h0, 4'hF, 32'hFFFFFF80, 32'd0);
        fetch(P + 32'h24, enc_s(12'd12, 5'd5, 5'd0, 3'd2));
        mem(32'hC, 4'h0, 4'hF, 32'h00000080, 32'd0);
        fetch(P + 32'h28, enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'b0010011));
        fetch(P + 32'h2C, enc_b(13'd8, 5'd6, 5'd1, 3'd4));
        fetch(P + 32'h34, enc_b(13'd8, 5'd6, 5'd1, 3'd6));
        fetch(P + 32'h38, enc_s(12'd6, 5'd1, 5'd0, 3'd1));
        mem(32'h4, 4'h0, 4'b1100, 32'hFFFF0000, 32'd0);
        fetch(P + 32'h3C, enc_i(12'd2, 5'd0, 3'd1, 5'd7, 7'b0000011));
        mem(32'h0, 4'b1100, 4'h0, 32'd0, 32'h80010000);
        fetch(P + 32'h40, enc_s(12'd0, 5'd7, 5'd0, 3'd2));
        mem(32'h0, 4'h0, 4'hF, 32'hFFFF8001, 32'd0);
        fetch(P + 32'h44, enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'b0010011));
        fetch(P + 32'h48, enc_s(12'd0, 5'd0, 5'd0, 3'd2));
        mem(32'h0, 4'h0, 4'hF, 32'h00000000, 32'd0);
        fetch(P + 32'h4C, enc_r(7'h20, 5'd1, 5'd6, 3'd0, 5'd8));
        fetch(P + 32'h50, enc_s(12'd0, 5'd8, 5'd0, 3'd2));
        mem(32'h0, 4'h0, 4'hF, 32'h00000002, 32'd0);
        fetch(P + 32'h54, enc_i(12'h404, 5'd7, 3'd5, 5'd9, 7'b0010011));
        fetch(P + 32'h58, enc_s(12'd0, 5'd9, 5'd0, 3'd2));
        mem(32'h0, 4'h0, 4'hF, 32'hFFFFF800, 32'd0);
        fetch(P + 32'h5C, enc_r(7'h00, 5'd1, 5'd6, 3'd3, 5'd10));
        fetch(P + 32'h60, enc_s(12'd0, 5'd10, 5'd0, 3'd2));
        mem(32'h0, 4'h0, 4'hF, 32'h00000001, 32'd0);
        fetch(P + 32'h64, {20'h00001, 5'd12, 7'b0010111});
        fetch(P + 32'h68, enc_s(12'd0, 5'd12, 5'd0, 3'd2));
        mem(32'h0, 4'h0, 4'hF, 32'h1ECEC064, 32'd0);
        fetch(P + 32'h6C, 32'h00000073);
        fetch(P + 32'h70, enc_j(21'd8, 5'd13));
        fetch(P + 32'h78, enc_s(12'd0, 5'd13, 5'd0, 3'd2));
        mem(32'h0, 4'h0, 4'hF, 32'h1ECEB074, 32'd0);
        fetch(P + 32'h7C, enc_i(12'd1, 5'd13, 3'd0, 5'd14, 7'b1100111));
        fetch(P + 32'h74, enc_s(12'd0, 5'd14, 5'd0, 3'd2));
        mem(32'h0, 4'h0, 4'hF, 32'h1ECEB080, 32'd0);
        fetch(P + 32'h78, enc_j(21'd0, 5'd0));
        fetch(P + 32'h78, enc_i(12'd0, 5'd0, 3'd2, 5'd15, 7'b0000011));

        for (int n = 0; n < 50 && dmem_rmask === 4'h0; n++) @(negedge clk);
        chk("pre_rst_rmask", 32'(dmem_rmask), 32'hF);
        rst       = 1'b1;
        dmem_resp = 1'b1;
        @(negedge clk);
        chk("rst_mid_rmask", 32'(dmem_rmask), 32'd0);
        chk("rst_mid_wmask", 32'(dmem_wmask), 32'd0);
        chk("rst_mid_imask", 32'(imem_rmask), 32'd0);
        @(negedge clk);
        dmem_resp = 1'b0;
        rst       = 1'b0;
        #1;
        chk("refetch_addr", imem_addr, P);
        chk("refetch_rmask", 32'(imem_rmask), 32'hF);
        @(negedge clk);
        chk("refetch_hold_addr", imem_addr, P);
        chk("refetch_hold_rmask", 32'(imem_rmask), 32'hF);
        chk("refetch_dmask", 32'(dmem_rmask | dmem_wmask), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv32i_cpu.md
RV32I_CPU -- requirements
Module: rv32i_cpu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1eceb000: address of the first instruction fetched after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port imem_addr, output, 32 bits: instruction fetch address, always 4-byte aligned.
REQ-005 SHALL have port imem_rmask, output, 4 bits: 4'b1111 while a fetch is pending, else 0.
REQ-006 SHALL have port imem_rdata, input, 32 bits: instruction word, valid only when imem_resp=1.
REQ-007 SHALL have port imem_resp, input, 1 bit: fetch completion strobe.
REQ-008 SHALL have port dmem_addr, output, 32 bits: data address, always 4-byte aligned.
REQ-009 SHALL have port dmem_rmask, output, 4 bits: byte lanes being read.
REQ-010 SHALL have port dmem_wmask, output, 4 bits: byte lanes being written.
REQ-011 SHALL have port dmem_wdata, output, 32 bits: store data, lane-aligned.
REQ-012 SHALL have port dmem_rdata, input, 32 bits: load data, valid only when dmem_resp=1.
REQ-013 SHALL have port dmem_resp, input, 1 bit: data access completion strobe.

Function
REQ-014 SHALL implement a multicycle in-order RV32I core with states FETCH, EXECUTE and MEMORY.
REQ-015 In FETCH, SHALL drive imem_addr=pc and imem_rmask=4'hF, holding both stable until imem_resp=1.
REQ-016 On imem_resp=1, SHALL latch imem_rdata, set imem_rmask=0 in the next cycle, and go to EXECUTE.
REQ-017 EXECUTE SHALL take exactly one cycle: decode, read operands, run ALU/branch logic.
REQ-018 For non-memory instructions, EXECUTE SHALL write rd, update pc, and return to FETCH.
REQ-019 A minimum non-memory instruction SHALL therefore take 2 cycles plus the fetch latency.
REQ-020 Loads and stores SHALL go from EXECUTE to MEMORY.
REQ-021 In MEMORY, SHALL drive dmem_addr=ea&~3 with rmask or wmask = size mask << ea[1:0], truncated to 4 bits, holding all stable until dmem_resp=1.
REQ-022 Size masks SHALL be: byte 4'b0001, half 4'b0011, word 4'b1111.
REQ-023 dmem_rmask and dmem_wmask SHALL never be nonzero simultaneously; both SHALL be 0 outside MEMORY.
REQ-024 Store data SHALL be rs2 shifted left by 8*ea[1:0].
REQ-025 Load data SHALL be rdata shifted right by 8*ea[1:0], then sign- or zero-extended per LB/LH/LW/LBU/LHU.
REQ-026 On dmem_resp=1, SHALL write the load result to rd, set pc=pc+4, and return to FETCH.
REQ-027 SHALL support all RV32I base instructions: LUI, AUIPC, JAL, JALR (target bit 0 cleared), BEQ/BNE/BLT/BGE/BLTU/BGEU, loads, stores, OP-IMM, OP.
REQ-028 Arithmetic SHALL be 32-bit modulo 2^32; shift amounts SHALL use the low 5 bits only.
REQ-029 SLT/SLTI SHALL compare signed and SLTU/SLTIU unsigned; SRA SHALL be arithmetic.
REQ-030 x0 SHALL always read 0; writes to x0 SHALL be discarded.
REQ-031 A source register equal to the rd being written in the same cycle SHALL read the old value.
REQ-032 FENCE, ECALL, EBREAK and unknown opcodes SHALL execute as no-ops with pc=pc+4.
REQ-033 A jump to self (pc_next==pc) SHALL be executed normally; this is the halt idiom.

Reset
REQ-034 While rst=1 at a clock edge: pc=RESET_PC, x1..x31=0, state=FETCH, all masks 0, dmem_wdata=0.
REQ-035 Reset mid-access SHALL abandon the request; masks SHALL be 0 in the cycle after the reset edge.
REQ-036 A resp arriving while rst=1 SHALL be ignored.
REQ-037 The first fetch SHALL be issued in the first cycle with rst=0.

Configuration
REQ-038 With macro RVFI_TRACE_EN defined, SHALL add output ports: commit_valid (1), commit_order (64), commit_pc_rdata (32), commit_pc_wdata (32), commit_insn (32), commit_rd_addr (5), commit_rd_wdata (32).
REQ-039 Under RVFI_TRACE_EN, commit_valid SHALL pulse for one cycle per retired instruction.
REQ-040 Under RVFI_TRACE_EN, commit_order SHALL start at 0 after reset and increment by 1 per retired instruction.
REQ-041 Under RVFI_TRACE_EN, commit_rd_addr and commit_rd_wdata SHALL be 0 when rd=x0 or there is no write.
REQ-042 Without RVFI_TRACE_EN, these ports and their logic SHALL be absent.

Verification
REQ-043 Reset, then release -> imem_addr=32'h1eceb000 and imem_rmask=4'hF in the first cycle after release.
REQ-044 ADDI x1,x0,-1; SRLI x2,x1,28 -> x1=32'hFFFFFFFF, x2=32'h0000000F.
REQ-045 SB x1 at ea=...02 with x1=32'h000000AB -> dmem_wmask=4'b0100 and dmem_wdata[23:16]=8'hAB.
REQ-046 LB at ea=...03 with rdata=32'h80000000 -> rd=32'hFFFFFF80; LBU at the same ea -> rd=32'h00000080.
REQ-047 BLT with rs1=-1, rs2=1 -> branch taken; BLTU with the same operands -> not taken, pc+4.
REQ-048 rst asserted while dmem_rmask!=0 -> masks 0 on the next cycle, then a fetch from RESET_PC.
